// File: rtl/mutative_replacement_unit.sv
// MRU-bit replacement engine for the mutative cache: runtime-selectable group size,
// per-set MRU tracking and a registered victim/occupancy result one cycle after a lookup.
module mutative_replacement_unit #(
  parameter int unsigned WAYS         = 8,
  parameter int unsigned SETS         = 16,
  parameter int unsigned WAY_IDX_BITS = $clog2(WAYS),
  parameter int unsigned SET_IDX_BITS = $clog2(SETS),
  parameter int unsigned MODE_BITS    = $clog2(WAY_IDX_BITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [MODE_BITS-1:0]    mode_i,
  input  logic                    mode_we_i,
  output logic [MODE_BITS-1:0]    mode_o,
  output logic                    busy_o,
  input  logic                    touch_valid_i,
  input  logic [SET_IDX_BITS-1:0] touch_set_i,
  input  logic [WAY_IDX_BITS-1:0] touch_way_i,
  input  logic                    lookup_valid_i,
  input  logic [SET_IDX_BITS-1:0] lookup_set_i,
  input  logic [WAY_IDX_BITS-1:0] lookup_tag_i,
  output logic                    victim_valid_o,
  output logic [WAY_IDX_BITS-1:0] victim_way_o,
  output logic [WAYS-1:0]         victim_we_o,
  output logic                    left_or_right_o,
  output logic                    tie_o
);

  logic [WAYS-1:0]         mru_q [SETS];
  logic [MODE_BITS-1:0]    mode_q, mode_clamped;
  logic                    busy_q;
  logic [SET_IDX_BITS-1:0] sweep_q;
  logic                    victim_valid_q;
  logic [WAY_IDX_BITS-1:0] victim_way_q, victim_way_d;
  logic [WAYS-1:0]         victim_we_q;
  logic                    lor_q, lor_d, tie_q, tie_d;

  logic [WAYS-1:0]         t_row, t_mask, t_hot, t_next;
  logic                    touch_en;
  logic [WAYS-1:0]         l_row;
  logic [WAY_IDX_BITS-1:0] l_base, half_bit;
  int                      cnt_lo, cnt_hi;

  assign mode_clamped = (int'(mode_i) > WAY_IDX_BITS) ? MODE_BITS'(WAY_IDX_BITS) : mode_i;

  // Touch path: group membership is "same index above the low mode bits".
  always_comb begin
    t_row  = mru_q[touch_set_i];
    t_mask = '0;
    t_hot  = '0;
    for (int w = 0; w < WAYS; w++) begin
      if ((WAY_IDX_BITS'(w) >> mode_q) == (touch_way_i >> mode_q)) t_mask[w] = 1'b1;
      if (WAY_IDX_BITS'(w) == touch_way_i) t_hot[w] = 1'b1;
    end
    t_next = t_row | t_hot;
    if ((t_next & t_mask) == t_mask) t_next = (t_row & ~t_mask) | t_hot;
    touch_en = touch_valid_i && !busy_q && (mode_q != '0) && !t_row[touch_way_i];
  end

  // Lookup path: descending scan leaves the lowest-index zero bit as victim.
  always_comb begin
    l_row        = mru_q[lookup_set_i];
    l_base       = (lookup_tag_i >> mode_q) << mode_q;
    half_bit     = (mode_q == '0) ? '0 : WAY_IDX_BITS'(1) << (mode_q - 1'b1);
    victim_way_d = l_base;
    cnt_lo       = 0;
    cnt_hi       = 0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if ((WAY_IDX_BITS'(w) >> mode_q) == (lookup_tag_i >> mode_q)) begin
        if (!l_row[w]) begin
          victim_way_d = WAY_IDX_BITS'(w);
        end else if ((WAY_IDX_BITS'(w) & half_bit) != '0) begin
          cnt_hi = cnt_hi + 1;
        end else begin
          cnt_lo = cnt_lo + 1;
        end
      end
    end
    if (mode_q == '0) begin
      victim_way_d = lookup_tag_i;
      lor_d        = 1'b0;
      tie_d        = 1'b1;
    end else begin
      lor_d = (cnt_lo < cnt_hi);
      tie_d = (cnt_lo == cnt_hi);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) mru_q[s] <= '0;
      mode_q         <= MODE_BITS'(WAY_IDX_BITS);
      busy_q         <= 1'b0;
      sweep_q        <= '0;
      victim_valid_q <= 1'b0;
      victim_way_q   <= '0;
      victim_we_q    <= '0;
      lor_q          <= 1'b0;
      tie_q          <= 1'b1;
    end else begin
      victim_valid_q <= lookup_valid_i && !busy_q;
      if (lookup_valid_i && !busy_q) begin
        victim_way_q <= victim_way_d;
        victim_we_q  <= WAYS'(1) << victim_way_d;
        lor_q        <= lor_d;
        tie_q        <= tie_d;
      end
      if (busy_q) begin
        mru_q[sweep_q] <= '0;
        sweep_q        <= sweep_q + 1'b1;
        if (sweep_q == SET_IDX_BITS'(SETS - 1)) busy_q <= 1'b0;
      end else begin
        if (mode_we_i) begin
          mode_q  <= mode_clamped;
          busy_q  <= 1'b1;
          sweep_q <= '0;
        end
        if (touch_en) mru_q[touch_set_i] <= t_next;
      end
    end
  end

  assign mode_o          = mode_q;
  assign busy_o          = busy_q;
  assign victim_valid_o  = victim_valid_q;
  assign victim_way_o    = victim_way_q;
  assign victim_we_o     = victim_we_q;
  assign left_or_right_o = lor_q;
  assign tie_o           = tie_q;

endmodule

// File: tb/tb_mutative_replacement_unit.sv
// Directed bench for mutative_replacement_unit (8 ways, 16 sets) with hand-computed results.
module tb_mutative_replacement_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_i;
  logic       mode_we_i;
  logic [1:0] mode_o;
  logic       busy_o;
  logic       touch_valid_i;
  logic [3:0] touch_set_i;
  logic [2:0] touch_way_i;
  logic       lookup_valid_i;
  logic [3:0] lookup_set_i;
  logic [2:0] lookup_tag_i;
  logic       victim_valid_o;
  logic [2:0] victim_way_o;
  logic [7:0] victim_we_o;
  logic       left_or_right_o;
  logic       tie_o;

  int n_vec = 0;
  int n_err = 0;

  mutative_replacement_unit #(.WAYS(8), .SETS(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mode_i          (mode_i),
    .mode_we_i       (mode_we_i),
    .mode_o          (mode_o),
    .busy_o          (busy_o),
    .touch_valid_i   (touch_valid_i),
    .touch_set_i     (touch_set_i),
    .touch_way_i     (touch_way_i),
    .lookup_valid_i  (lookup_valid_i),
    .lookup_set_i    (lookup_set_i),
    .lookup_tag_i    (lookup_tag_i),
    .victim_valid_o  (victim_valid_o),
    .victim_way_o    (victim_way_o),
    .victim_we_o     (victim_we_o),
    .left_or_right_o (left_or_right_o),
    .tie_o           (tie_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic touch(input logic [3:0] s, input logic [2:0] w);
    touch_valid_i = 1'b1;
    touch_set_i   = s;
    touch_way_i   = w;
    step();
    touch_valid_i = 1'b0;
  endtask

  task automatic lookup(input logic [3:0] s, input logic [2:0] t);
    lookup_valid_i = 1'b1;
    lookup_set_i   = s;
    lookup_tag_i   = t;
    step();
    lookup_valid_i = 1'b0;
  endtask

  task automatic chk_victim(input string tag, input logic [2:0] way, input logic lor,
                            input logic tie);
    check({tag, "_valid"}, victim_valid_o, 1'b1);
    check({tag, "_way"}, victim_way_o, way);
    check({tag, "_we"}, victim_we_o, 8'h01 << way);
    check({tag, "_lor"}, left_or_right_o, lor);
    check({tag, "_tie"}, tie_o, tie);
  endtask

  // Mode write, then run out the sweep with lookups and ignored mode writes applied.
  task automatic write_mode_sweep(input logic [1:0] m, input logic [1:0] exp_mode);
    int cycles;
    mode_i    = m;
    mode_we_i = 1'b1;
    step();
    mode_we_i = 1'b0;
    check("mode_latched", mode_o, exp_mode);
    check("busy_rise", busy_o, 1'b1);
    cycles         = busy_o ? 1 : 0;
    mode_i         = exp_mode ^ 2'd1;
    mode_we_i      = 1'b1;
    lookup_valid_i = 1'b1;
    lookup_set_i   = 4'd0;
    lookup_tag_i   = 3'd0;
    while (busy_o && cycles < 40) begin
      step();
      if (victim_valid_o !== 1'b0) check("sweep_no_victim", victim_valid_o, 1'b0);
      if (busy_o) cycles++;
    end
    mode_we_i      = 1'b0;
    lookup_valid_i = 1'b0;
    check("sweep_len", cycles, 16);
    check("mode_hold_busy", mode_o, exp_mode);
  endtask

  initial begin
    rst_n = 1'b0; mode_i = '0; mode_we_i = 1'b0;
    touch_valid_i = 1'b0; touch_set_i = '0; touch_way_i = '0;
    lookup_valid_i = 1'b0; lookup_set_i = '0; lookup_tag_i = '0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_mode", mode_o, 2'd3);
    check("rst_busy", busy_o, 1'b0);
    check("rst_valid", victim_valid_o, 1'b0);
    check("rst_way", victim_way_o, 3'd0);
    check("rst_we", victim_we_o, 8'h00);
    check("rst_lor", left_or_right_o, 1'b0);
    check("rst_tie", tie_o, 1'b1);

    lookup(4'd3, 3'd0);
    chk_victim("first", 3'd0, 1'b0, 1'b1);
    step();
    check("pulse_low", victim_valid_o, 1'b0);
    check("hold_we", victim_we_o, 8'h01);

    // Mode 3, set 5: ways 0..6 -> 0x7F, lower 4 vs upper 3
    for (int w = 0; w < 7; w++) touch(4'd5, 3'(w));
    lookup(4'd5, 3'd0);
    chk_victim("m3_fill7", 3'd7, 1'b0, 1'b0);
    touch(4'd5, 3'd7);
    lookup(4'd5, 3'd0);
    chk_victim("m3_wrap", 3'd0, 1'b1, 1'b0);

    // Set 9 = 0x07 so stale state would show as victim 3 in mode 2
    for (int w = 0; w < 3; w++) touch(4'd9, 3'(w));
    write_mode_sweep(2'd2, 2'd2);
    lookup(4'd9, 3'd0);
    chk_victim("m2_swept", 3'd0, 1'b0, 1'b1);

    touch(4'd2, 3'd4);
    touch(4'd2, 3'd5);
    lookup(4'd2, 3'd4);
    chk_victim("m2_hi", 3'd6, 1'b0, 1'b0);
    lookup(4'd2, 3'd0);
    chk_victim("m2_lo_untouched", 3'd0, 1'b0, 1'b1);

    write_mode_sweep(2'd1, 2'd1);
    lookup(4'd2, 3'd6);
    chk_victim("m1_swept", 3'd6, 1'b0, 1'b1);
    touch(4'd2, 3'd4);
    lookup(4'd2, 3'd4);
    chk_victim("m1_one", 3'd5, 1'b0, 1'b0);
    touch(4'd2, 3'd5);
    lookup(4'd2, 3'd5);
    chk_victim("m1_wrap", 3'd4, 1'b1, 1'b0);
    touch(4'd2, 3'd5);
    lookup(4'd2, 3'd4);
    chk_victim("m1_set_nochg", 3'd4, 1'b1, 1'b0);

    write_mode_sweep(2'd0, 2'd0);
    lookup(4'd2, 3'd5);
    chk_victim("m0_tag5", 3'd5, 1'b0, 1'b1);
    touch(4'd2, 3'd3);
    lookup(4'd2, 3'd3);
    chk_victim("m0_tag3", 3'd3, 1'b0, 1'b1);

    // Mode write 7 truncates to 2'b11 == full associativity; reset on sweep cycle 4
    mode_i    = 2'(7);
    mode_we_i = 1'b1;
    step();
    mode_we_i = 1'b0;
    check("m7_mode", mode_o, 2'd3);
    step();
    step();
    step();
    check("mid_sweep_busy", busy_o, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_busy", busy_o, 1'b0);
    check("abort_mode", mode_o, 2'd3);
    lookup(4'd12, 3'd0);
    chk_victim("abort_clear", 3'd0, 1'b0, 1'b1);

    // Same-cycle touch+lookup on set 1 sees pre-touch state
    touch_valid_i = 1'b1; touch_set_i = 4'd1; touch_way_i = 3'd0;
    lookup(4'd1, 3'd0);
    touch_valid_i = 1'b0;
    chk_victim("same_set_pre", 3'd0, 1'b0, 1'b1);
    lookup(4'd1, 3'd0);
    chk_victim("same_set_post", 3'd1, 1'b0, 1'b0);

    touch_valid_i = 1'b1; touch_set_i = 4'd3; touch_way_i = 3'd0;
    lookup(4'd4, 3'd0);
    touch_valid_i = 1'b0;
    chk_victim("diff_set", 3'd0, 1'b0, 1'b1);
    lookup(4'd3, 3'd0);
    chk_victim("diff_set_post", 3'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mutative_replacement_unit.md
Name: mutative_replacement_unit

Overview:
Parametrised replacement-state engine for the mutative cache. It tracks per-set MRU bits and selects victims for any associativity from direct-mapped up to WAYS-way. Associativity is changed at runtime by a mode write, which triggers a hardware sweep that clears stale state in every set. It sits beside the tag/data arrays: the cache controller sends hit/fill touches and victim lookups, and receives a registered one-hot victim write-enable plus left/right occupancy hints.

Parameters:
WAYS, 8, physical way count; power of 2, >=2
SETS, 16, set count; power of 2, >=2
WAY_IDX_BITS, $clog2(WAYS), way index width (derived)
SET_IDX_BITS, $clog2(SETS), set index width (derived)
MODE_BITS, $clog2(WAY_IDX_BITS+1), mode field width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
mode_i  in  MODE_BITS  requested log2(group size): 0 = direct-mapped, WAY_IDX_BITS = fully WAYS-way
mode_we_i  in  1  latch mode_i and start clear sweep
mode_o  out  MODE_BITS  current active mode
busy_o  out  1  sweep in progress
touch_valid_i  in  1  hit/fill update strobe
touch_set_i  in  SET_IDX_BITS  set being touched
touch_way_i  in  WAY_IDX_BITS  way being touched
lookup_valid_i  in  1  victim request
lookup_set_i  in  SET_IDX_BITS  set for lookup
lookup_tag_i  in  WAY_IDX_BITS  low tag bits; select the way group
victim_valid_o  out  1  victim result valid (one-cycle pulse)
victim_way_o  out  WAY_IDX_BITS  chosen victim way
victim_we_o  out  WAYS  one-hot of victim_way_o
left_or_right_o  out  1  1 = lower half of group has fewer MRU bits set than upper half
tie_o  out  1  both halves have equal MRU counts

Behaviour:
- Reset (rst_n=0 at clk edge): all MRU bits 0; mode_o = WAY_IDX_BITS; busy_o = 0; victim_valid_o = 0, victim_way_o = 0, victim_we_o = 0; left_or_right_o = 0, tie_o = 1. Reset during a sweep aborts it.
- Group: G = 2^mode; base = lookup_tag_i (or touch_way_i for touches) with low mode bits cleared; the group is ways base..base+G-1.
- Mode change: mode_we_i with busy_o=0 latches mode_i; values > WAY_IDX_BITS clamp to WAY_IDX_BITS. busy_o rises the next cycle, and the sweep clears set 0..SETS-1, one set per cycle. busy_o falls after exactly SETS cycles. mode_we_i during busy_o is ignored. Writing the mode equal to the current mode still sweeps.
- During busy_o: touch and lookup are ignored; victim_valid_o stays 0.
- Touch, mode>0: if the touched bit is already 1, no change. If setting it would make all G group bits 1, clear the group and set only the touched bit. Otherwise set the bit. Bits outside the group are untouched. Mode 0: no state change.
- Lookup latency: 1 cycle. victim_valid_o pulses the cycle after lookup_valid_i and holds no other state. Outputs hold their last value when not valid.
- Victim selection:
  - Mode 0: victim = lookup_tag_i.
  - Otherwise: lowest-index zero bit in the group. If the group has no zero bit (unreachable by construction), victim = base.
  - victim_we_o = 1 << victim_way_o.
- Occupancy hints, registered with the victim:
  - left = count of set bits in the group's lower G/2 ways; right = count in the upper G/2 ways.
  - left_or_right_o = (left < right); tie_o = (left == right).
  - Mode 0: left_or_right_o = 0, tie_o = 1.
- Simultaneous touch and lookup to the same set: the lookup uses pre-touch state. The touch commits at the same edge.
- Touch and lookup to different sets proceed independently each cycle; full throughput of 1 touch + 1 lookup per cycle.

Test Plan:
- Reset, then lookup set 3, tag 0 in mode 3 -> next cycle victim_valid_o=1, victim_way_o=0, victim_we_o=8'h01, tie_o=1.
- Mode 3, set 5: touch ways 0..6 -> lookup gives way 7. Touch way 7 -> set 5 bits = 8'h80. Lookup -> way 0, left_or_right_o=1.
- Mode 2, tag 3'b1xx, set 2: touch ways 4,5 -> lookup victim 6, left_or_right_o=0, tie_o=0. Ways 0-3 bits remain 0.
- Mode write 1 from mode 3 after populating sets -> busy_o high exactly 16 cycles; lookups during the sweep give no victim_valid_o. After the sweep, every set reads all-zero (victim = group base, e.g. tag 3'b110 -> way 6).
- Mode 0: lookup tag 5 -> victim_way_o=5, victim_we_o=8'h20. Touches cause no state change. Mode_i=7 write -> mode_o=3.
- Assert rst_n=0 mid-sweep (cycle 4) -> next cycle busy_o=0, mode_o=3, all bits 0. Same-cycle touch+lookup on set 1 -> victim reflects pre-touch state.
